// File: rtl/gcd_job_arbiter_pkg.sv
// gcd_job_arbiter_pkg: shared FSM state encoding, default parameters and sizing helper
package gcd_job_arbiter_pkg;
    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_PRESET  = 2;
    localparam int DEF_SETUP   = 2;
    localparam int DEF_ENTER   = 1;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_PRST = 4'd1,
        ST_SETX = 4'd2,
        ST_ENTX = 4'd3,
        ST_SETY = 4'd4,
        ST_ENTY = 4'd5,
        ST_RUN  = 4'd6,
        ST_DONE = 4'd7
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        m = (d > m) ? d : m;
        return m;
    endfunction
endpackage

// File: rtl/gcd_job_arbiter_rr_arbiter.sv
// gcd_job_arbiter_rr_arbiter: combinational round-robin pick of the lowest requester at/after ptr
//   req   : pending requests
//   ptr   : first index to consider
//   grant : one-hot winner, idx : winner index, valid : any request pending
module gcd_job_arbiter_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            valid
);
    logic [PW-1:0] j;

    // Scan offsets from the farthest down to zero so the nearest request at/after ptr wins last.
    always_comb begin
        j     = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % NREQ);
            if (req[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
        grant = valid ? (NREQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/gcd_job_arbiter.sv
// gcd_job_arbiter: shares one GCD processor between NREQ requesters, sequencing reset/X/Y/run per job
//   clock, reset (sync, active-low)
//   req/req_x/req_y        : requester jobs, operands packed W bits per requester
//   ack/resp_data/resp_err : one-cycle completion pulse with result or error
//   busy                   : job in progress
//   proc_*                 : sole driver/observer of the processor (reset/enter active-low)
module gcd_job_arbiter
    import gcd_job_arbiter_pkg::*;
#(
    parameter int NREQ          = DEF_NREQ,
    parameter int W             = DEF_W,
    parameter int PRESET_CYCLES = DEF_PRESET,
    parameter int SETUP_CYCLES  = DEF_SETUP,
    parameter int ENTER_CYCLES  = DEF_ENTER,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      resp_data,
    output logic              resp_err,
    output logic              busy,
    output logic              proc_reset,
    output logic              proc_enter,
    output logic [W-1:0]      proc_data_in,
    input  logic [W-1:0]      proc_data_out,
    input  logic              proc_halt
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(max4(TIMEOUT, PRESET_CYCLES, SETUP_CYCLES, ENTER_CYCLES) + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   idx_q, idx_d, ptr_q, ptr_d;
    logic [W-1:0]    x_q, x_d, y_q, y_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [W-1:0]    resp_data_q, resp_data_d, proc_data_in_q, proc_data_in_d;
    logic            resp_err_q, resp_err_d, busy_q, busy_d;
    logic            proc_reset_q, proc_reset_d, proc_enter_q, proc_enter_d;

    logic [NREQ-1:0] g_grant;
    logic [PW-1:0]   g_idx;
    logic            g_valid;
    logic [W-1:0]    x_sel, y_sel;
    logic            cnt_z;

    gcd_job_arbiter_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .grant (g_grant),
        .idx   (g_idx),
        .valid (g_valid)
    );

    always_comb begin
        x_sel = '0;
        y_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_idx == PW'(i)) begin
                x_sel = req_x[i*W +: W];
                y_sel = req_y[i*W +: W];
            end
        end
    end

    // Each timed state stays while the shared counter is nonzero; every exit reloads it for the next state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        ptr_d          = ptr_q;
        x_d            = x_q;
        y_d            = y_q;
        ack_d          = ack_q;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        busy_d         = busy_q;
        proc_reset_d   = proc_reset_q;
        proc_enter_d   = proc_enter_q;
        proc_data_in_d = proc_data_in_q;
        cnt_z          = (cnt_q == '0);
        case (state_q)
            ST_IDLE: begin
                proc_reset_d = 1'b0;
                proc_enter_d = 1'b1;
                if (g_valid) begin
                    idx_d  = g_idx;
                    x_d    = x_sel;
                    y_d    = y_sel;
                    busy_d = 1'b1;
                    if (x_sel == '0 || y_sel == '0) begin
                        state_d     = ST_DONE;
                        ack_d       = g_grant;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end else begin
                        state_d = ST_PRST;
                        cnt_d   = CW'(PRESET_CYCLES - 1);
                    end
                end
            end
            ST_PRST: begin
                if (cnt_z) begin
                    state_d        = ST_SETX;
                    cnt_d          = CW'(SETUP_CYCLES - 1);
                    proc_reset_d   = 1'b1;
                    proc_data_in_d = x_q;
                end else cnt_d = cnt_q - 1'b1;
            end
            ST_SETX: begin
                if (cnt_z) begin
                    state_d      = ST_ENTX;
                    cnt_d        = CW'(ENTER_CYCLES - 1);
                    proc_enter_d = 1'b0;
                end else cnt_d = cnt_q - 1'b1;
            end
            ST_ENTX: begin
                if (cnt_z) begin
                    state_d        = ST_SETY;
                    cnt_d          = CW'(SETUP_CYCLES - 1);
                    proc_enter_d   = 1'b1;
                    proc_data_in_d = y_q;
                end else cnt_d = cnt_q - 1'b1;
            end
            ST_SETY: begin
                if (cnt_z) begin
                    state_d      = ST_ENTY;
                    cnt_d        = CW'(ENTER_CYCLES - 1);
                    proc_enter_d = 1'b0;
                end else cnt_d = cnt_q - 1'b1;
            end
            ST_ENTY: begin
                if (cnt_z) begin
                    state_d      = ST_RUN;
                    cnt_d        = CW'(TIMEOUT - 1);
                    proc_enter_d = 1'b1;
                end else cnt_d = cnt_q - 1'b1;
            end
            ST_RUN: begin
                if (proc_halt || cnt_z) begin
                    state_d     = ST_DONE;
                    ack_d       = NREQ'(1) << idx_q;
                    resp_err_d  = !proc_halt;
                    resp_data_d = proc_halt ? proc_data_out : '0;
                end else cnt_d = cnt_q - 1'b1;
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                ack_d        = '0;
                resp_data_d  = '0;
                resp_err_d   = 1'b0;
                busy_d       = 1'b0;
                proc_reset_d = 1'b0;
                ptr_d        = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            ptr_q          <= '0;
            x_q            <= '0;
            y_q            <= '0;
            ack_q          <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            busy_q         <= 1'b0;
            proc_reset_q   <= 1'b0;
            proc_enter_q   <= 1'b1;
            proc_data_in_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            ptr_q          <= ptr_d;
            x_q            <= x_d;
            y_q            <= y_d;
            ack_q          <= ack_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            busy_q         <= busy_d;
            proc_reset_q   <= proc_reset_d;
            proc_enter_q   <= proc_enter_d;
            proc_data_in_q <= proc_data_in_d;
        end
    end

    assign ack          = ack_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign busy         = busy_q;
    assign proc_reset   = proc_reset_q;
    assign proc_enter   = proc_enter_q;
    assign proc_data_in = proc_data_in_q;
endmodule

// File: tb/tb_gcd_job_arbiter.sv
// tb_gcd_job_arbiter: table-driven and hand-sequenced checks of the GCD job arbiter against a processor stub
module tb_gcd_job_arbiter;
    localparam int NREQ = 4, W = 8, P = 2, S = 2, E = 1, TO = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_x, req_y;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      resp_data, proc_data_in, proc_data_out;
    logic              resp_err, busy, proc_reset, proc_enter;
    logic              proc_halt = 1'b0;

    gcd_job_arbiter #(
        .NREQ(NREQ), .W(W), .PRESET_CYCLES(P), .SETUP_CYCLES(S), .ENTER_CYCLES(E), .TIMEOUT(TO)
    ) dut (
        .clock(clk), .reset(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
        .ack(ack), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
        .proc_reset(proc_reset), .proc_enter(proc_enter), .proc_data_in(proc_data_in),
        .proc_data_out(proc_data_out), .proc_halt(proc_halt)
    );

    // Processor stub: loads operands on enter falling edges, then one Euclid step per cycle.
    logic [W-1:0] sx = '0, sy = '0, lx = '0, ly = '0;
    logic [1:0]   phase = 2'd0;
    logic         enter_prev = 1'b1;
    logic         never_halt = 1'b0;

    always @(posedge clk) begin
        if (!proc_reset) begin
            phase      <= 2'd0;
            proc_halt  <= 1'b0;
            enter_prev <= 1'b1;
        end else begin
            enter_prev <= proc_enter;
            if (enter_prev && !proc_enter) begin
                if (phase == 2'd0) begin
                    sx <= proc_data_in; lx <= proc_data_in; phase <= 2'd1;
                end else if (phase == 2'd1) begin
                    sy <= proc_data_in; ly <= proc_data_in; phase <= 2'd2;
                end
            end else if (phase == 2'd2 && !never_halt) begin
                if (sy == '0) begin
                    phase <= 2'd3; proc_halt <= 1'b1;
                end else begin
                    sx <= sy; sy <= sx % sy;
                end
            end
        end
    end
    assign proc_data_out = sx;

    typedef struct {
        int         idx;
        logic [7:0] x, y, exp;
        logic       err;
    } vec_t;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [7:0]      data;
        logic            err;
    } exp_t;

    vec_t tbl[8];
    exp_t sb[$];
    int   n_vec = 0, n_bad = 0, n_ack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ack !== '0) begin
            n_ack++;
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL unexpected_ack: got ack=%b with nothing expected", ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack", 32'(ack), 32'(e.ack));
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [7:0] data, input logic err);
        exp_t e;
        e.ack = NREQ'(1) << idx; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic drive(input int idx, input logic [7:0] x, input logic [7:0] y);
        req_x[idx*W +: W] = x;
        req_y[idx*W +: W] = y;
        req[idx] = 1'b1;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int b;
        b = budget;
        while (n_ack < target && b > 0) begin
            step;
            b--;
        end
        if (n_ack < target) begin
            n_vec++; n_bad++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", n_ack, target);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = '0;
        repeat (2) step;
        sb.delete();
        rst_n = 1'b1;
        step;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, cnt;
        tbl[0] = '{0,  8'd50,  8'd20,  8'd10,  1'b0};
        tbl[1] = '{1,  8'd48,  8'd18,  8'd6,   1'b0};
        tbl[2] = '{2,  8'd0,   8'd9,   8'd0,   1'b1};
        tbl[3] = '{3,  8'd35,  8'd21,  8'd7,   1'b0};
        tbl[4] = '{1,  8'd17,  8'd5,   8'd1,   1'b0};
        tbl[5] = '{2,  8'd255, 8'd255, 8'd255, 1'b0};
        tbl[6] = '{3,  8'd9,   8'd0,   8'd0,   1'b1};
        tbl[7] = '{0,  8'd13,  8'd8,   8'd1,   1'b0};
        rst_n = 1'b0; req = '0; req_x = '0; req_y = '0;
        step; step;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_proc_reset", 32'(proc_reset), 0);
        chk("rst_proc_enter", 32'(proc_enter), 1);
        chk("rst_proc_data_in", 32'(proc_data_in), 0);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < 8; i++) begin
            base = n_ack;
            push(tbl[i].idx, tbl[i].exp, tbl[i].err);
            drive(tbl[i].idx, tbl[i].x, tbl[i].y);
            step;
            chk("busy", 32'(busy), 1);
            req_x[tbl[i].idx*W +: W] = 8'hFF;
            req_y[tbl[i].idx*W +: W] = 8'hFF;
            if (i % 2 == 1) req[tbl[i].idx] = 1'b0;
            wait_acks(base + 1, 60);
            req[tbl[i].idx] = 1'b0;
            if (!tbl[i].err) begin
                chk("proc_x", 32'(lx), 32'(tbl[i].x));
                chk("proc_y", 32'(ly), 32'(tbl[i].y));
            end
            step;
        end

        // zero operand: ack right after the grant cycle, processor held in reset
        do_reset;
        base = n_ack;
        push(2, 8'd0, 1'b1);
        drive(2, 8'd0, 8'd9);
        step;
        chk("zero_latency", 32'(n_ack - base), 1);
        chk("zero_proc_reset", 32'(proc_reset), 0);
        req[2] = 1'b0;
        step;
        chk("zero_proc_reset2", 32'(proc_reset), 0);
        step;

        // simultaneous requests from a fresh pointer
        do_reset;
        base = n_ack;
        push(0, 8'd6, 1'b0);
        push(1, 8'd7, 1'b0);
        drive(0, 8'd48, 8'd18);
        drive(1, 8'd35, 8'd21);
        wait_acks(base + 1, 60);
        req[0] = 1'b0;
        wait_acks(base + 2, 60);
        req[1] = 1'b0;
        step;

        // processor never halts: timeout error after TO run cycles
        never_halt = 1'b1;
        base = n_ack;
        push(0, 8'd0, 1'b1);
        drive(0, 8'd50, 8'd20);
        cnt = 0;
        while (n_ack == base && cnt < 80) begin
            step;
            cnt++;
        end
        chk("timeout_latency", 32'(cnt), 32'(1 + P + 2 * (S + E) + TO));
        req[0] = 1'b0;
        step;

        // reset in the middle of RUN drops the job; the reissued job completes
        base = n_ack;
        push(0, 8'd6, 1'b0);
        drive(0, 8'd48, 8'd18);
        repeat (14) step;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        step;
        chk("mid_proc_reset", 32'(proc_reset), 0);
        chk("mid_busy_clr", 32'(busy), 0);
        chk("mid_ack", 32'(ack), 0);
        chk("mid_no_ack", 32'(n_ack), 32'(base));
        sb.delete();
        never_halt = 1'b0;
        rst_n = 1'b1;
        push(0, 8'd6, 1'b0);
        wait_acks(base + 1, 60);
        req[0] = 1'b0;
        step;

        // two requesters held high must alternate
        do_reset;
        base = n_ack;
        push(0, 8'd2, 1'b0);
        push(1, 8'd3, 1'b0);
        push(0, 8'd2, 1'b0);
        push(1, 8'd3, 1'b0);
        drive(0, 8'd6, 8'd4);
        drive(1, 8'd9, 8'd6);
        wait_acks(base + 4, 200);
        req = '0;
        repeat (3) step;
        chk("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
